// File: rtl/prog_load_ctrl_if.sv
// Boot-load bus: serial byte stream in, memory write strobes and status out.
// Latency: none, this file only bundles signals.
// Backpressure: rx_ready from the slave gates byte acceptance.
// Ports (slave = loader side):
//   rx_data/rx_valid/rx_ready   byte stream handshake
//   restart                     single-cycle reload request
//   loading/done/error          load status
//   load_addr/load_data         write address and 128-bit line shift register
//   dmem_we/imem_we             one-cycle write strobes
interface prog_load_ctrl_if #(
    parameter int ADDR_LEN = 32
);
    logic [7:0]          rx_data;
    logic                rx_valid;
    logic                rx_ready;
    logic                restart;
    logic                loading;
    logic [ADDR_LEN-1:0] load_addr;
    logic [127:0]        load_data;
    logic                dmem_we;
    logic                imem_we;
    logic                done;
    logic                error;

    modport master (
        output rx_data, rx_valid, restart,
        input  rx_ready, loading, load_addr, load_data,
               dmem_we, imem_we, done, error
    );

    modport slave (
        input  rx_data, rx_valid, restart,
        output rx_ready, loading, load_addr, load_data,
               dmem_we, imem_we, done, error
    );
endinterface

// File: rtl/prog_load_ctrl.sv
// Boot loader: parses a 4-byte LE length header, then packs bytes into words/lines and strobes dmem/imem writes.
// Latency: write strobes fire 1 cycle after the 4th byte of a word; header decision visible 1 cycle after its 4th byte.
// Backpressure: none during HDR/LOAD (rx_ready=1); rx_ready=0 in DONE/ERR until restart.
// Ports:
//   clk      single clock, rising edge
//   reset_x  asynchronous active-low reset
//   bus      prog_load_ctrl_if slave modport (byte stream in, write strobes/status out)
module prog_load_ctrl #(
    parameter int LOAD_BYTES = 8192,
    parameter int ADDR_LEN   = 32
) (
    input  logic              clk,
    input  logic              reset_x,
    prog_load_ctrl_if.slave   bus
);

    localparam int REM_W = $clog2(LOAD_BYTES) + 1;

    typedef enum logic [1:0] {
        S_HDR  = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t              r_state;
    logic [1:0]          r_byte_cnt;
    logic [23:0]         r_shift;      // first three bytes of the current header/word
    logic [REM_W-1:0]    r_remaining;
    logic [ADDR_LEN-1:0] r_load_addr;
    logic [127:0]        r_load_data;
    logic                r_dmem_we;
    logic                r_imem_we;
    logic                r_loading;
    logic                r_done;
    logic                r_error;

    logic                w_rx_ready;
    logic                w_accept;
    logic [31:0]         w_word;
    logic                w_hdr_bad;
    logic                w_last_word;

    assign w_rx_ready  = (r_state == S_HDR) || (r_state == S_LOAD);
    assign w_accept    = bus.rx_valid & w_rx_ready;
    // Completed little-endian word when the incoming byte is the 4th one.
    assign w_word      = {bus.rx_data, r_shift};
    assign w_hdr_bad   = (w_word == 32'd0) || (w_word[3:0] != 4'd0) ||
                         (w_word > 32'(LOAD_BYTES));
    assign w_last_word = (r_remaining == REM_W'(4));

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            r_state     <= S_HDR;
            r_byte_cnt  <= 2'd0;
            r_shift     <= 24'd0;
            r_remaining <= '0;
            r_load_addr <= '0;
            r_load_data <= '0;
            r_dmem_we   <= 1'b0;
            r_imem_we   <= 1'b0;
            r_loading   <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_dmem_we <= 1'b0;
            r_imem_we <= 1'b0;
            case (r_state)
                S_HDR: begin
                    if (w_accept) begin
                        r_shift    <= {bus.rx_data, r_shift[23:8]};
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            if (w_hdr_bad) begin
                                r_state <= S_ERR;
                                r_error <= 1'b1;
                            end else begin
                                r_state     <= S_LOAD;
                                r_remaining <= w_word[REM_W-1:0];
                                r_load_addr <= '0;
                            end
                        end
                    end
                end
                S_LOAD: begin
                    // End of a strobe cycle: advance, or finish on the final word.
                    // The address is held on the final word so it never passes LOAD_BYTES-4.
                    if (r_dmem_we) begin
                        r_remaining <= r_remaining - REM_W'(4);
                        if (w_last_word) begin
                            r_state    <= S_DONE;
                            r_loading  <= 1'b0;
                            r_done     <= 1'b1;
                            r_byte_cnt <= 2'd0;
                        end else begin
                            r_load_addr <= r_load_addr + ADDR_LEN'(4);
                        end
                    end
                    // A byte arriving during the final strobe cycle belongs to no word; drop it.
                    if (w_accept && !(r_dmem_we && w_last_word)) begin
                        r_shift    <= {bus.rx_data, r_shift[23:8]};
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            r_load_data <= {w_word, r_load_data[127:32]};
                            r_dmem_we   <= 1'b1;
                            r_imem_we   <= (r_load_addr[3:2] == 2'b11);
                        end
                    end
                end
                S_DONE, S_ERR: begin
                    if (bus.restart) begin
                        r_state     <= S_HDR;
                        r_loading   <= 1'b1;
                        r_done      <= 1'b0;
                        r_error     <= 1'b0;
                        r_load_addr <= '0;
                        r_load_data <= '0;
                        r_byte_cnt  <= 2'd0;
                        r_shift     <= 24'd0;
                        r_remaining <= '0;
                    end
                end
                default: r_state <= S_HDR;
            endcase
        end
    end

    assign bus.rx_ready  = w_rx_ready;
    assign bus.loading   = r_loading;
    assign bus.load_addr = r_load_addr;
    assign bus.load_data = r_load_data;
    assign bus.dmem_we   = r_dmem_we;
    assign bus.imem_we   = r_imem_we;
    assign bus.done      = r_done;
    assign bus.error     = r_error;

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Testbench for prog_load_ctrl: random images checked against a line/word model of the load.
// Latency: n/a.
// Backpressure: n/a.
module tb_prog_load_ctrl;

    logic clk = 1'b0;
    logic reset_x = 1'b0;
    always #5 clk = ~clk;

    prog_load_ctrl_if #(.ADDR_LEN(32)) bus();

    prog_load_ctrl #(.LOAD_BYTES(8192), .ADDR_LEN(32)) dut (
        .clk     (clk),
        .reset_x (reset_x),
        .bus     (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [31:0]  addr;
        logic [31:0]  word;
        logic         dmem;
        logic         imem;
        logic [127:0] line;
    } wr_t;

    wr_t wr_q[$];

    // Record every strobe cycle.
    always @(negedge clk) begin
        if (bus.dmem_we === 1'b1 || bus.imem_we === 1'b1) begin
            wr_t e;
            e.addr = bus.load_addr;
            e.word = bus.load_data[127:96];
            e.dmem = bus.dmem_we;
            e.imem = bus.imem_we;
            e.line = bus.load_data;
            wr_q.push_back(e);
        end
    end

    // Model: word i of the image lands at byte address 4*i; every 4th word
    // completes a 16-byte line made of the image bytes of that line, LE.
    function automatic int count_bad(input logic [7:0] img[$]);
        int bad;
        int nw;
        logic [31:0]  w;
        logic [127:0] ln;
        bad = 0;
        nw  = img.size() / 4;
        if (wr_q.size() != nw) bad++;
        for (int i = 0; i < nw; i++) begin
            w = {img[4*i+3], img[4*i+2], img[4*i+1], img[4*i]};
            ln = '0;
            for (int k = 0; k < 16; k++) ln[8*k +: 8] = img[16*(i/4) + k];
            if (i >= wr_q.size()) bad++;
            else if (wr_q[i].addr !== 32'(4*i) || wr_q[i].word !== w ||
                     wr_q[i].dmem !== 1'b1 || wr_q[i].imem !== ((i % 4) == 3) ||
                     ((i % 4) == 3 && wr_q[i].line !== ln))
                bad++;
        end
        return bad;
    endfunction

    function automatic int imem_count();
        int c;
        c = 0;
        foreach (wr_q[i]) if (wr_q[i].imem === 1'b1) c++;
        return c;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        if (max_gap > 0) begin
            repeat ($urandom_range(max_gap, 0)) begin
                bus.rx_valid = 1'b0;
                @(negedge clk);
            end
        end
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        if (bus.rx_ready !== 1'b1) begin
            n_total++;
            $display("FAIL rx_ready_during_load: got %b, need 1", bus.rx_ready);
        end
        @(negedge clk);
    endtask

    task automatic send_hdr(input logic [31:0] n, input int max_gap);
        for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8], max_gap);
    endtask

    task automatic send_image(input logic [7:0] img[$], input int max_gap);
        foreach (img[i]) send_byte(img[i], max_gap);
    endtask

    task automatic make_img(input int n, output logic [7:0] img[$]);
        img.delete();
        for (int i = 0; i < n; i++) img.push_back(8'($urandom));
    endtask

    task automatic idle(input int n);
        bus.rx_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_restart();
        bus.restart = 1'b1;
        @(negedge clk);
        bus.restart = 1'b0;
    endtask

    task automatic test_reset();
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.restart  = 1'b0;
        reset_x      = 1'b0;
        #12;
        n_total++; if (bus.loading !== 1'b1) $display("FAIL reset_loading: got %b, need 1", bus.loading); else n_pass++;
        n_total++; if (bus.rx_ready !== 1'b1) $display("FAIL reset_rx_ready: got %b, need 1", bus.rx_ready); else n_pass++;
        n_total++; if ({bus.dmem_we, bus.imem_we, bus.done, bus.error} !== 4'b0000)
            $display("FAIL reset_flags: got %b, need 0000", {bus.dmem_we, bus.imem_we, bus.done, bus.error}); else n_pass++;
        n_total++; if (bus.load_addr !== 32'd0 || bus.load_data !== 128'd0)
            $display("FAIL reset_addr_data: got %h/%h, need 0/0", bus.load_addr, bus.load_data); else n_pass++;
        @(negedge clk);
        reset_x = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_minimal();
        logic [7:0] img[$];
        int bad;
        wr_q.delete();
        for (int i = 0; i < 16; i++) img.push_back(8'(i));
        send_hdr(32'd16, 0);
        for (int i = 0; i < 15; i++) send_byte(img[i], 0);
        send_byte(img[15], 0);
        bus.rx_valid = 1'b0;
        // Now in the strobe cycle of the last word.
        n_total++; if ({bus.dmem_we, bus.imem_we} !== 2'b11)
            $display("FAIL min_last_strobe: got %b, need 11", {bus.dmem_we, bus.imem_we}); else n_pass++;
        n_total++; if (bus.load_addr !== 32'd12) $display("FAIL min_last_addr: got %0d, need 12", bus.load_addr); else n_pass++;
        n_total++; if (bus.load_data !== 128'h0F0E0D0C_0B0A0908_07060504_03020100)
            $display("FAIL min_line: got %h, need 0f0e0d0c0b0a090807060504030201 00", bus.load_data); else n_pass++;
        n_total++; if (bus.loading !== 1'b1) $display("FAIL min_loading_in_strobe: got %b, need 1", bus.loading); else n_pass++;
        @(negedge clk);
        n_total++; if ({bus.dmem_we, bus.loading, bus.done} !== 3'b001)
            $display("FAIL min_release: got we/loading/done=%b, need 001", {bus.dmem_we, bus.loading, bus.done}); else n_pass++;
        n_total++; if (wr_q.size() > 0 && wr_q[0].word !== 32'h03020100)
            $display("FAIL min_word0: got %h, need 03020100", wr_q[0].word); else n_pass++;
        bad = count_bad(img);
        n_total++; if (bad !== 0) $display("FAIL min_writes: got %0d bad of %0d writes, need 0 bad of 4", bad, wr_q.size()); else n_pass++;
    endtask

    task automatic test_done_ignores();
        wr_q.delete();
        n_total++; if (bus.rx_ready !== 1'b0) $display("FAIL done_rx_ready: got %b, need 0", bus.rx_ready); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            bus.rx_data  = 8'($urandom);
            bus.rx_valid = 1'b1;
            @(negedge clk);
        end
        bus.rx_valid = 1'b0;
        n_total++; if (wr_q.size() !== 0 || bus.done !== 1'b1)
            $display("FAIL done_ignores_bytes: got %0d writes done=%b, need 0 writes done=1", wr_q.size(), bus.done); else n_pass++;
    endtask

    task automatic test_reload();
        pulse_restart();
        n_total++; if ({bus.loading, bus.done, bus.rx_ready} !== 3'b101)
            $display("FAIL reload_state: got loading/done/ready=%b, need 101", {bus.loading, bus.done, bus.rx_ready}); else n_pass++;
        n_total++; if (bus.load_addr !== 32'd0 || bus.load_data !== 128'd0)
            $display("FAIL reload_clear: got %h/%h, need 0/0", bus.load_addr, bus.load_data); else n_pass++;
    endtask

    task automatic test_throttled();
        logic [7:0] img[$];
        int bad;
        wr_q.delete();
        make_img(32, img);
        send_hdr(32'd32, 3);
        send_image(img, 3);
        idle(3);
        bad = count_bad(img);
        n_total++; if (bad !== 0) $display("FAIL thr_writes: got %0d bad of %0d writes, need 0 bad of 8", bad, wr_q.size()); else n_pass++;
        n_total++; if (imem_count() !== 2) $display("FAIL thr_imem_count: got %0d, need 2", imem_count()); else n_pass++;
        n_total++; if (wr_q.size() > 0 && wr_q[wr_q.size()-1].addr !== 32'd28)
            $display("FAIL thr_last_addr: got %0d, need 28", wr_q[wr_q.size()-1].addr); else n_pass++;
        n_total++; if (bus.done !== 1'b1) $display("FAIL thr_done: got %b, need 1", bus.done); else n_pass++;
    endtask

    task automatic test_bad_headers();
        int hdrs[3];
        hdrs = '{0, 20, 8208};
        pulse_restart();
        foreach (hdrs[h]) begin
            wr_q.delete();
            send_hdr(32'(hdrs[h]), 0);
            bus.rx_valid = 1'b0;
            n_total++; if ({bus.error, bus.rx_ready, bus.loading} !== 3'b101)
                $display("FAIL bad_hdr_%0d: got error/ready/loading=%b, need 101", hdrs[h], {bus.error, bus.rx_ready, bus.loading}); else n_pass++;
            idle(4);
            n_total++; if (wr_q.size() !== 0) $display("FAIL bad_hdr_%0d_strobes: got %0d, need 0", hdrs[h], wr_q.size()); else n_pass++;
            pulse_restart();
            n_total++; if ({bus.error, bus.rx_ready} !== 2'b01)
                $display("FAIL bad_hdr_%0d_restart: got error/ready=%b, need 01", hdrs[h], {bus.error, bus.rx_ready}); else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] img[$];
        int bad;
        wr_q.delete();
        make_img(64, img);
        send_hdr(32'd64, 0);
        for (int i = 0; i < 23; i++) send_byte(img[i], 0);
        bus.rx_valid = 1'b0;
        n_total++; if (wr_q.size() !== 5) $display("FAIL arst_pre_writes: got %0d, need 5", wr_q.size()); else n_pass++;
        #2;
        reset_x = 1'b0;
        #1;
        n_total++; if ({bus.loading, bus.dmem_we, bus.imem_we, bus.done, bus.rx_ready} !== 5'b10001)
            $display("FAIL arst_flags: got %b, need 10001", {bus.loading, bus.dmem_we, bus.imem_we, bus.done, bus.rx_ready}); else n_pass++;
        n_total++; if (bus.load_addr !== 32'd0 || bus.load_data !== 128'd0)
            $display("FAIL arst_addr_data: got %h/%h, need 0/0", bus.load_addr, bus.load_data); else n_pass++;
        @(negedge clk);
        reset_x = 1'b1;
        @(negedge clk);
        wr_q.delete();
        make_img(16, img);
        send_hdr(32'd16, 0);
        send_image(img, 0);
        idle(3);
        bad = count_bad(img);
        n_total++; if (bad !== 0 || bus.done !== 1'b1)
            $display("FAIL arst_fresh_load: got %0d bad done=%b, need 0 bad done=1", bad, bus.done); else n_pass++;
    endtask

    task automatic test_full();
        logic [7:0] img[$];
        int bad;
        pulse_restart();
        wr_q.delete();
        make_img(8192, img);
        send_hdr(32'd8192, 0);
        send_image(img, 0);
        idle(3);
        bad = count_bad(img);
        n_total++; if (wr_q.size() !== 2048) $display("FAIL full_dmem_count: got %0d, need 2048", wr_q.size()); else n_pass++;
        n_total++; if (imem_count() !== 512) $display("FAIL full_imem_count: got %0d, need 512", imem_count()); else n_pass++;
        n_total++; if (bad !== 0) $display("FAIL full_writes: got %0d bad, need 0", bad); else n_pass++;
        n_total++; if (bus.load_addr !== 32'd8188) $display("FAIL full_final_addr: got %0d, need 8188", bus.load_addr); else n_pass++;
        n_total++; if ({bus.done, bus.loading, bus.rx_ready} !== 3'b100)
            $display("FAIL full_end_state: got done/loading/ready=%b, need 100", {bus.done, bus.loading, bus.rx_ready}); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_minimal();
        test_done_ignores();
        test_reload();
        test_throttled();
        test_bad_headers();
        test_async_reset();
        test_full();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/prog_load_ctrl.md
# prog_load_ctrl

Sequencer for the boot-time program/data load path. It accepts a byte stream from the serial receiver, assembles little-endian 32-bit words and 128-bit instruction lines, and issues one `dmem` write per word and one `imem_ld` write per line. It holds the `pipeline` in reset for the whole load, then releases it. It is the source of `prog_loading`, `prog_loadaddr`, `prog_loaddata`, `prog_dmem_we` and `prog_imem_we` in `top`.

## Interface
- `LOAD_BYTES`, default 8192: maximum image size in bytes, equal to the `imem_ld` capacity of 512 lines × 16 B; must be a multiple of 16.
- `ADDR_LEN`, default 32: address width, matching `` `ADDR_LEN ``.
- `clk` in 1: single clock; all state changes on its posedge.
- `reset_x` in 1: asynchronous, active-low reset.
- `rx_data` in 8: incoming byte.
- `rx_valid` in 1: `rx_data` valid.
- `rx_ready` out 1: byte accepted on a posedge where `rx_valid & rx_ready`.
- `restart` in 1: single-cycle request to reload; honoured only in DONE or ERR.
- `loading` out 1: core held in reset (drives `prog_loading`).
- `load_addr` out ADDR_LEN: byte address of the word being written.
- `load_data` out 128: line shift register; `[127:96]` is the current word.
- `dmem_we` out 1: one-cycle data-memory write strobe.
- `imem_we` out 1: one-cycle instruction-memory write strobe (line address is `load_addr[12:4]`).
- `done` out 1: load completed successfully.
- `error` out 1: header rejected.

## Operation
- States: HDR, LOAD, DONE, ERR. Reset state is HDR.
- `rx_ready` = (state==HDR || state==LOAD). It is combinational from state, so it reads 1 during and after reset.
- **HDR:**
  - Accept 4 bytes, little-endian, into a 32-bit length N.
  - After the 4th byte, check N:
    - N==0, N%16≠0, or N>LOAD_BYTES → ERR.
    - Otherwise → LOAD with word address 0 and remaining count N.
- **LOAD:**
  - Bytes fill a 32-bit word little-endian: byte 0 → `[7:0]`, byte 3 → `[31:24]`.
  - On acceptance of a word's 4th byte, `load_data` shifts right by 32 and the new word enters `[127:96]`. After 4 words, word0 sits at `[31:0]` and word3 at `[127:96]`.
  - Next cycle: `dmem_we`=1 and `load_addr` = word byte address, which is 4×word index.
  - If that word is the 4th of a line (address bits [3:2]==3), `imem_we`=1 in the same cycle.
  - `load_addr` then advances by 4 and remaining decrements by 4.
  - No back-pressure is needed: a write cycle does not block byte acceptance in that cycle.
- **Final word** (remaining reaches 0): after the write-pulse cycle, go to DONE.
- **DONE:**
  - `loading`=0 and `done`=1.
  - `rx_ready`=0; bytes are ignored.
- **ERR:**
  - `loading`=1 and `error`=1.
  - `rx_ready`=0.
- **restart in DONE/ERR:** next cycle go to HDR.
  - Set `loading`=1 and clear `done`/`error`.
  - Clear `load_addr`, `load_data` and the byte counter.
- **restart in HDR/LOAD:** ignored.
- **Reset values:**
  - `loading`=1, `load_addr`=0, `load_data`=0.
  - `dmem_we`=0, `imem_we`=0, `done`=0, `error`=0.
  - Byte counter=0, remaining=0.
- **Reset asserted mid-load:** all state is cleared immediately (asynchronously), with no partial-word write. After release, the loader waits for a new header.
- **Widths:**
  - Remaining count is `$clog2(LOAD_BYTES)+1` bits.
  - `load_addr` never exceeds LOAD_BYTES-4, so no wrap occurs within a legal image.

## Timing
- Byte to write latency: strobes assert exactly 1 cycle after the posedge accepting the word's 4th byte, for exactly 1 cycle.
- Strobe spacing: with `rx_valid` held high, `dmem_we` fires every 4 cycles and `imem_we` every 16 cycles.
- `load_addr`/`load_data` are stable throughout the strobe cycle and change only after it.
- Release timing: `loading` falls, and `done` rises, on the cycle after the final strobe cycle.
- Header latency: the HDR→LOAD or HDR→ERR decision is visible the cycle after the 4th header byte.
- Restart latency: 1 cycle.
- Gaps in `rx_valid` stall progress only; partial word/line state is held indefinitely.

## Test plan
- **Minimal image:** header N=16, then bytes 0x00..0x0F back-to-back → `dmem_we` at addresses 0,4,8,12 with `[127:96]` = 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C. `imem_we` once, at address 12, with `load_data`=0x0F0E0D0C_0B0A0908_07060504_03020100. `loading` falls 1 cycle after that strobe.
- **Bad headers:** N=0, N=20 and N=8208 → `error`=1, `rx_ready`=0, `loading`=1 and no strobes. Then `restart` → HDR, `error`=0 next cycle.
- **Throttled stream:** N=32 with random `rx_valid` gaps → identical write sequence to the gap-free run, 8 `dmem_we` and 2 `imem_we`, with the last at address 28.
- **Async reset mid-load:** N=64, assert `reset_x` low after 23 data bytes → outputs go to reset values without waiting for a clock edge. A fresh N=16 load then completes from address 0.
- **Full capacity:** N=8192 → 2048 `dmem_we` and 512 `imem_we`, final `load_addr`=8188. `done`=1, and further bytes are not accepted.
- **Reload:** after DONE, `restart` → `loading`=1 next cycle; a second image overwrites from address 0.
